// File: rtl/bram_port_arbiter_pkg.sv
// Shared types and constants for the two-port BRAM arbiter.
// Holds the FSM state encoding, hold-counter width and port indices.
package bram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int HOLD_W = 8;
  localparam int PORT0  = 0;
  localparam int PORT1  = 1;

  // Maps a winning port index onto the matching ownership state.
  function automatic arb_state_e own_state(input logic port);
    return port ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/bram_rr_pick.sv
// Combinational two-way round-robin pick: a lone requester wins outright,
// and on contention the port named by prio_i wins.
module bram_rr_pick (
  input  logic [1:0] req_i,
  input  logic       prio_i,
  output logic [1:0] win_o
);

  always_comb begin
    win_o = 2'b00;
    case (req_i)
      2'b01:   win_o = 2'b01;
      2'b10:   win_o = 2'b10;
      2'b11:   win_o = prio_i ? 2'b10 : 2'b01;
      default: win_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM between a CPU-side port and a DMA port: one word access per
// cycle, round-robin with a bounded lock, combinational grant, 1-cycle read return.
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int MAX_HOLD   = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  REQ0,
  input  logic                  LOCK0,
  input  logic [3:0]            WE0,
  input  logic [ADDR_WIDTH-1:0] ADDR0,
  input  logic [31:0]           WDATA0,
  output logic                  GNT0,
  output logic                  RVALID0,
  output logic [31:0]           RDATA0,
  input  logic                  REQ1,
  input  logic                  LOCK1,
  input  logic [3:0]            WE1,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  input  logic [31:0]           WDATA1,
  output logic                  GNT1,
  output logic                  RVALID1,
  output logic [31:0]           RDATA1,
  output logic [ADDR_WIDTH-1:0] BRAM_RDADDR,
  output logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
  output logic [31:0]           BRAM_WDATA,
  output logic [3:0]            BRAM_WRITE,
  input  logic [31:0]           BRAM_RDATA
);

  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

  arb_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              prio_q, prio_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;

  logic              keepOwn0, keepOwn1;
  logic              rrPrio;
  logic [1:0]        pickWin;
  logic [1:0]        gnt;
  logic              winLock;

  assign keepOwn0 = (state_q == OWN0) & REQ0 & LOCK0 & (hold_q < HOLD_LIMIT);
  assign keepOwn1 = (state_q == OWN1) & REQ1 & LOCK1 & (hold_q < HOLD_LIMIT);

  // prio_q names the favoured port; leaving an ownership hands priority to the other port.
  always_comb begin
    rrPrio = prio_q;
    if (state_q == OWN0) begin
      rrPrio = 1'b1;
    end else if (state_q == OWN1) begin
      rrPrio = 1'b0;
    end
  end

  bram_rr_pick u_pick (
    .req_i  ({REQ1, REQ0}),
    .prio_i (rrPrio),
    .win_o  (pickWin)
  );

  // Grants are suppressed while reset is held so the BRAM sees no access.
  always_comb begin
    gnt = 2'b00;
    if (HRESETn) begin
      if (keepOwn0) begin
        gnt = 2'b01;
      end else if (keepOwn1) begin
        gnt = 2'b10;
      end else begin
        gnt = pickWin;
      end
    end
  end

  assign GNT0 = gnt[PORT0];
  assign GNT1 = gnt[PORT1];

  assign winLock = gnt[PORT1] ? LOCK1 : LOCK0;

  always_comb begin
    state_d = IDLE;
    hold_d  = '0;
    prio_d  = prio_q;
    if (keepOwn0 | keepOwn1) begin
      state_d = state_q;
      hold_d  = (hold_q == '1) ? hold_q : hold_q + HOLD_W'(1);
    end else if (gnt != 2'b00) begin
      prio_d = ~gnt[PORT1];
      if (winLock) begin
        state_d = own_state(gnt[PORT1]);
        hold_d  = HOLD_W'(1);
      end
    end
  end

  always_comb begin
    BRAM_RDADDR = '0;
    BRAM_WRADDR = '0;
    BRAM_WDATA  = '0;
    BRAM_WRITE  = '0;
    if (gnt[PORT0]) begin
      BRAM_RDADDR = ADDR0;
      BRAM_WRADDR = ADDR0;
      BRAM_WDATA  = WDATA0;
      BRAM_WRITE  = WE0;
    end else if (gnt[PORT1]) begin
      BRAM_RDADDR = ADDR1;
      BRAM_WRADDR = ADDR1;
      BRAM_WDATA  = WDATA1;
      BRAM_WRITE  = WE1;
    end
  end

  assign rvalid0_d = gnt[PORT0] & (WE0 == 4'b0000);
  assign rvalid1_d = gnt[PORT1] & (WE1 == 4'b0000);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      prio_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      prio_q    <= prio_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign RVALID0 = rvalid0_q;
  assign RVALID1 = rvalid1_q;
  assign RDATA0  = BRAM_RDATA;
  assign RDATA1  = BRAM_RDATA;

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one single-port-per-direction block RAM between two requesters (port 0: CPU-side bus adapter; port 1: DMA/peripheral engine).
- Issues at most one word access per cycle, using round-robin arbitration with an optional bounded burst lock.
- Drives the same BRAM interface as the AHB-lite RAM slave: separate read/write address, byte-write strobes, synchronous read with 1-cycle latency.
- Sits between the requesters and the BRAM instance.

Parameters:
- ADDR_WIDTH, 14, word-address width of the BRAM.
- MAX_HOLD, 8, max consecutive grants a locking port keeps before forced re-arbitration (legal range 1..255).

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
REQ0  in  1  port 0 access request
LOCK0  in  1  port 0 asks to keep ownership on following cycles
WE0  in  4  port 0 byte write strobes; 0 = read
ADDR0  in  ADDR_WIDTH  port 0 word address
WDATA0  in  32  port 0 write data
GNT0  out  1  port 0 access accepted this cycle
RVALID0  out  1  port 0 read data valid
RDATA0  out  32  port 0 read data
REQ1, LOCK1, WE1, ADDR1, WDATA1, GNT1, RVALID1, RDATA1: same as port 0, for port 1
BRAM_RDADDR  out  ADDR_WIDTH  BRAM read address
BRAM_WRADDR  out  ADDR_WIDTH  BRAM write address
BRAM_WDATA  out  32  BRAM write data
BRAM_WRITE  out  4  BRAM byte write enables
BRAM_RDATA  in  32  BRAM read data, valid 1 cycle after address

Behaviour:
- Reset values:
  - GNT0/1 = 0, RVALID0/1 = 0, BRAM_WRITE = 0, BRAM addresses and BRAM_WDATA = 0.
  - State = IDLE, round-robin pointer favours port 0, hold counter = 0.
- Reset mid-operation: outstanding read is dropped and RVALID is forced low immediately.
- Grant timing:
  - Grant is combinational in the request cycle.
  - GNTx = 1 means the BRAM is driven from port x in that same cycle.
  - At most one GNT per cycle. A requester must hold REQ and its payload until it sees GNT.
- BRAM drive:
  - BRAM_RDADDR = BRAM_WRADDR = ADDR of the granted port.
  - BRAM_WDATA = WDATA of the granted port.
  - BRAM_WRITE = WE of the granted port. It is 0 when no grant or when the access is a read.
- Read return:
  - RVALIDx is registered, high exactly one cycle after a granted read (WEx = 0).
  - RDATAx = BRAM_RDATA unconditionally; data is only meaningful while RVALIDx = 1.
  - Back-to-back reads give RVALID on consecutive cycles.
- State machine: IDLE, OWN0, OWN1.
  - IDLE, or any state where re-arbitration occurs:
    - If only one port requests, it wins.
    - If both request, the port not granted last wins (pointer).
    - The winner's state becomes OWNx if its LOCKx = 1, else IDLE. Pointer updates to the winner.
  - OWNx: if REQx & LOCKx and hold count < MAX_HOLD:
    - Port x wins regardless of the other port.
    - Hold count increments.
  - Otherwise the block re-arbitrates as above, giving the other port priority when it requests.
  - Hold count resets to 1 on entry to OWNx and to 0 in IDLE.
  - Hold counter is 8 bits wide, saturating; it never wraps.
- Ownership loss: if the owner drops REQ in OWNx, the state returns to IDLE in the same arbitration, with no wasted cycle.
- Empty cycle: no requests → no grant, BRAM_WRITE = 0, state → IDLE.
- Same address from both ports: the accesses are serialized in grant order. A read granted after a write to the same word returns the new data.
- Fixed latency; no backpressure on the read return path.

Decomposition:
- Shared package holds:
  - State encoding: IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2.
  - Hold-counter width constant HOLD_W = 8.
  - Port index constants.
- One natural sub-module: bram_rr_pick, a combinational 2-way round-robin pick (requests, pointer → one-hot winner).
- FSM, counter and datapath mux stay in the top.

Test Plan:
- Reset: assert HRESETn = 0 during a granted read → RVALID0/1 = 0, BRAM_WRITE = 0 next edge; after release the first contention goes to port 0.
- Single port: REQ0 write WE0 = 4'hF, ADDR0 = 0x010, WDATA0 = 0xDEADBEEF, then a read of the same address → GNT0 both cycles, BRAM_WRITE = F then 0, RVALID0 on cycle 3 with RDATA0 = 0xDEADBEEF.
- Contention without lock: REQ0 = REQ1 = 1 for 4 cycles → grants alternate 0,1,0,1; RVALID follows the matching port one cycle later.
- Lock limit: MAX_HOLD = 4, LOCK1 = REQ1 = 1, REQ0 = 1 → port 1 is granted 4 cycles, then port 0 once, then port 1 again.
- Owner drop: in OWN0, port 0 drops REQ0 with REQ1 = 1 → GNT1 in that same cycle, state IDLE.
- Byte write: WE1 = 4'b0100, WDATA1 = 0x00AB0000 over 0x11223344 → subsequent read returns 0x11AB3344.
